// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew
// Undoes the staircase skew on the systolic array's output edge. Lane k
// arrives k cycles after lane 0. It is delayed by 9-k enabled cycles so that
// all ten lanes land in word_o on the same edge. The block also tracks row
// validity and counts rows per tile.
module systolic_output_deskew #(
    parameter  int DATA_WIDTH = 8,
    parameter  int ROWS       = 10,
    localparam int LANES      = 10,
    localparam int WORD_WIDTH = LANES * DATA_WIDTH,
    localparam int CNT_WIDTH  = $clog2(ROWS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic                  valid_i,
    input  logic [WORD_WIDTH-1:0] skew_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  valid_o,
    output logic [CNT_WIDTH-1:0]  row_cnt_o,
    output logic                  done_o
);

    // Aligned row as it will be loaded into word_o on the next enabled edge.
    logic [WORD_WIDTH-1:0] word_d;

    // Lane 9 is the last to arrive, so it needs no delay.
    assign word_d[(LANES-1)*DATA_WIDTH +: DATA_WIDTH] = skew_i[(LANES-1)*DATA_WIDTH +: DATA_WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < LANES - 1; gi++) begin : g_lane
            localparam int DEPTH = LANES - 1 - gi;

            logic [DEPTH*DATA_WIDTH-1:0] chain_q;
            logic [DEPTH*DATA_WIDTH-1:0] chain_d;

            // New samples enter at the low end. The oldest sample sits at the top.
            if (DEPTH > 1) begin : g_deep
                assign chain_d = {chain_q[(DEPTH-1)*DATA_WIDTH-1:0],
                                  skew_i[gi*DATA_WIDTH +: DATA_WIDTH]};
            end else begin : g_single
                assign chain_d = skew_i[gi*DATA_WIDTH +: DATA_WIDTH];
            end

            // Per-lane delay chain. It advances only on enabled cycles.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    chain_q <= '0;
                end else if (clr_i) begin
                    chain_q <= '0;
                end else if (en_i) begin
                    chain_q <= chain_d;
                end
            end

            assign word_d[gi*DATA_WIDTH +: DATA_WIDTH] = chain_q[DEPTH*DATA_WIDTH-1 -: DATA_WIDTH];
        end
    endgenerate

    // Validity travels alongside lane 0 through a 9-deep shift register.
    logic [LANES-2:0] valid_sr_q;
    logic [LANES-2:0] valid_sr_d;

    assign valid_sr_d = {valid_sr_q[LANES-3:0], valid_i};

    logic [WORD_WIDTH-1:0] word_q;
    logic                  valid_q;
    logic [CNT_WIDTH-1:0]  row_cnt_q;
    logic [CNT_WIDTH-1:0]  row_cnt_d;
    logic                  done_q;
    logic                  done_d;

    // Row counter next state. It wraps to 0 on the ROWS-th row and raises done alongside.
    always_comb begin
        row_cnt_d = row_cnt_q;
        done_d    = 1'b0;
        if (valid_sr_q[LANES-2]) begin
            if (row_cnt_q == CNT_WIDTH'(ROWS - 1)) begin
                row_cnt_d = '0;
                done_d    = 1'b1;
            end else begin
                row_cnt_d = row_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Output and tracking registers. Clear wins over enable, and a stall holds everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_sr_q <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            row_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else if (clr_i) begin
            valid_sr_q <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            row_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else if (en_i) begin
            valid_sr_q <= valid_sr_d;
            word_q     <= word_d;
            valid_q    <= valid_sr_q[LANES-2];
            row_cnt_q  <= row_cnt_d;
            done_q     <= done_d;
        end
    end

    assign word_o    = word_q;
    assign valid_o   = valid_q;
    assign row_cnt_o = row_cnt_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Testbench for systolic_output_deskew.
// The reference model keeps a history of the last ten enabled-cycle input
// samples. On each enabled edge, the expected lane k is taken from the sample
// that was presented 9-k enabled cycles earlier.
module tb_systolic_output_deskew;

    localparam int DW    = 8;
    localparam int ROWS  = 10;
    localparam int LANES = 10;
    localparam int WW    = LANES * DW;
    localparam int CW    = $clog2(ROWS + 1);

    logic          clk_i;
    logic          rst_ni;
    logic          en_i;
    logic          clr_i;
    logic          valid_i;
    logic [WW-1:0] skew_i;
    logic [WW-1:0] word_o;
    logic          valid_o;
    logic [CW-1:0] row_cnt_o;
    logic          done_o;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [WW-1:0] hist_skew [LANES];
    logic          hist_val  [LANES];
    logic [WW-1:0] exp_word;
    logic          exp_valid;
    int            exp_cnt;
    logic          exp_done;

    systolic_output_deskew #(.DATA_WIDTH(DW), .ROWS(ROWS)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (en_i),
        .clr_i     (clr_i),
        .valid_i   (valid_i),
        .skew_i    (skew_i),
        .word_o    (word_o),
        .valid_o   (valid_o),
        .row_cnt_o (row_cnt_o),
        .done_o    (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            hist_skew[i] = '0;
            hist_val[i]  = 1'b0;
        end
        exp_word  = '0;
        exp_valid = 1'b0;
        exp_cnt   = 0;
        exp_done  = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic clr, input logic v, input logic [WW-1:0] s);
        if (clr) begin
            model_reset();
        end else if (en) begin
            for (int i = LANES - 1; i > 0; i--) begin
                hist_skew[i] = hist_skew[i-1];
                hist_val[i]  = hist_val[i-1];
            end
            hist_skew[0] = s;
            hist_val[0]  = v;
            for (int k = 0; k < LANES; k++)
                exp_word[k*DW +: DW] = hist_skew[LANES-1-k][k*DW +: DW];
            exp_valid = hist_val[LANES-1];
            exp_done  = 1'b0;
            if (exp_valid) begin
                exp_cnt = exp_cnt + 1;
                if (exp_cnt == ROWS) begin
                    exp_cnt  = 0;
                    exp_done = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [WW-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[WW-1:0];
    endfunction

    // Staircase stream. At cycle c, lane k carries row c-k when that row exists.
    // Otherwise the lane carries random filler.
    // mode 0: lane value 0x10+k; mode 1: lane value r*16+k.
    function automatic logic [WW-1:0] stair(input int c, input int nrows, input int mode);
        logic [WW-1:0] w;
        w = rand_word();
        for (int k = 0; k < LANES; k++) begin
            int r;
            r = c - k;
            if (r >= 0 && r < nrows)
                w[k*DW +: DW] = (mode == 0) ? DW'(8'h10 + k) : DW'(r * 16 + k);
        end
        return w;
    endfunction

    function automatic logic [WW-1:0] tile_row(input int r);
        logic [WW-1:0] w;
        for (int k = 0; k < LANES; k++) w[k*DW +: DW] = DW'(r * 16 + k);
        return w;
    endfunction

    // One clock cycle: drive the inputs, update the model at the edge, then check #1 later.
    task automatic step(input logic en, input logic clr, input logic v, input logic [WW-1:0] s);
        en_i    = en;
        clr_i   = clr;
        valid_i = v;
        skew_i  = s;
        @(posedge clk_i);
        model_edge(en, clr, v, s);
        #1;
        chk("word", word_o, exp_word);
        chk("valid", WW'(valid_o), WW'(exp_valid));
        chk("row_cnt", WW'(row_cnt_o), WW'(exp_cnt));
        chk("done", WW'(done_o), WW'(exp_done));
        if (valid_o)
            $display("row out word=%h cnt=%0d done=%0b", word_o, row_cnt_o, done_o);
    endtask

    logic [WW-1:0] single_row;

    initial begin
        logic [79:0] sr;
        sr = 80'h19181716151413121110;
        single_row = sr[WW-1:0];

        // Reset with all-ones input.
        rst_ni  = 1'b0;
        en_i    = 1'b1;
        clr_i   = 1'b0;
        valid_i = 1'b1;
        skew_i  = '1;
        model_reset();
        #12;
        chk("rst_word", word_o, '0);
        chk("rst_valid", WW'(valid_o), '0);
        chk("rst_cnt", WW'(row_cnt_o), '0);
        chk("rst_done", WW'(done_o), '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 9; c++) begin
            step(1'b1, 1'b0, 1'b0, rand_word());
            chk("idle_valid", WW'(valid_o), '0);
        end

        // Single row: the aligned word appears on the 10th edge.
        for (int c = 0; c < 10; c++) step(1'b1, 1'b0, c == 0, stair(c, 1, 0));
        chk("single_word", word_o, single_row);
        chk("single_valid", WW'(valid_o), WW'(1));
        chk("single_cnt", WW'(row_cnt_o), WW'(1));
        step(1'b1, 1'b0, 1'b0, rand_word());
        chk("single_one_cycle", WW'(valid_o), '0);

        // Stall of three cycles, starting at t+4.
        for (int c = 0; c < 10; c++) begin
            if (c == 4)
                for (int s = 0; s < 3; s++) step(1'b0, 1'b0, 1'($urandom), rand_word());
            step(1'b1, 1'b0, c == 0, stair(c, 1, 0));
        end
        chk("stall_word", word_o, single_row);
        chk("stall_valid", WW'(valid_o), WW'(1));
        chk("stall_cnt", WW'(row_cnt_o), WW'(2));

        // Back-to-back tile of ten rows, starting from a cleared counter.
        step(1'b1, 1'b1, 1'b0, rand_word());
        for (int c = 0; c < 19; c++) begin
            step(1'b1, 1'b0, c < 10, stair(c, 10, 1));
            if (c >= 9) begin
                chk("tile_word", word_o, tile_row(c - 9));
                chk("tile_done", WW'(done_o), WW'(c == 18));
                chk("tile_cnt", WW'(row_cnt_o), WW'((c == 18) ? 0 : c - 8));
            end
        end

        // A clear with rows in flight. No stale row may ever become valid.
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, c < 3, stair(c, 3, 0));
        step(1'b1, 1'b1, 1'b1, rand_word());
        chk("clr_word", word_o, '0);
        chk("clr_valid", WW'(valid_o), '0);
        chk("clr_cnt", WW'(row_cnt_o), '0);
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b0, 1'b0, rand_word());
            chk("clr_no_stale", WW'(valid_o), '0);
        end
        for (int c = 0; c < 10; c++) step(1'b1, 1'b0, c == 0, stair(c, 1, 0));
        chk("post_clr_word", word_o, single_row);
        chk("post_clr_cnt", WW'(row_cnt_o), WW'(1));

        // Asynchronous reset asserted mid-tile, when row_cnt is 5.
        step(1'b1, 1'b1, 1'b0, rand_word());
        for (int c = 0; c < 14; c++) step(1'b1, 1'b0, c < 10, stair(c, 10, 1));
        chk("mid_cnt5", WW'(row_cnt_o), WW'(5));
        #3;
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("arst_word", word_o, '0);
        chk("arst_valid", WW'(valid_o), '0);
        chk("arst_cnt", WW'(row_cnt_o), '0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 19; c++) begin
            step(1'b1, 1'b0, c < 10, stair(c, 10, 1));
            chk("arst_tile_done", WW'(done_o), WW'(c == 18));
        end

        // Randomized traffic with stalls and occasional clears.
        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                 1'($urandom), rand_word());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
